conv_bram_1d_pass_sched: RTL and testbench

//  Multi-pass scheduler for the 1-D BRAM conv engine (ctrl + per-filter dpaths).

---
 rtl/conv_bram_1d_pass_sched_if.sv | 33 +++
 rtl/conv_bram_1d_pass_sched.sv | 141 ++++++++++++++
 tb/tb_conv_bram_1d_pass_sched.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_bram_1d_pass_sched_if.sv
// Control bundle between the pass scheduler and its loader / conv engine.
interface conv_bram_1d_pass_sched_if #(
    parameter int PASS_W = 5,
    parameter int RES_AW = 5
);
    logic              start;
    logic [PASS_W-1:0] num_pass;
    logic              busy;
    logic              done;
    logic              fill_req;
    logic              fill_bank;
    logic              fill_done;
    logic              eng_val;
    logic              eng_rdy;
    logic              eng_bank;
    logic [PASS_W-1:0] fil_sel;
    logic              res_wren;
    logic [RES_AW-1:0] res_wraddr;

    modport master (
        input  start, num_pass, fill_done, eng_rdy,
        input  res_wren, res_wraddr,
        output busy, done, fill_req, fill_bank,
        output eng_val, eng_bank, fil_sel
    );

    modport slave (
        output start, num_pass, fill_done, eng_rdy,
        output res_wren, res_wraddr,
        input  busy, done, fill_req, fill_bank,
        input  eng_val, eng_bank, fil_sel
    );
endinterface

// File: rtl/conv_bram_1d_pass_sched.sv
// Multi-pass ping-pong bank scheduler for the 1-D BRAM conv engine.
// Optional CONV_SCHED_PERF_EN adds a WAIT_BUF stall counter (perf_stall).
module conv_bram_1d_pass_sched #(
    parameter int IMG_W    = 32,
    parameter int FILTER_L = 3,
    parameter int STRIDE_W = 1,
    parameter int MAX_PASS = 16,
    localparam int RESULT_W = (IMG_W - FILTER_L) / STRIDE_W + 1,
    localparam int RES_AW   = $clog2(RESULT_W),
    localparam int PASS_W   = $clog2(MAX_PASS + 1)
) (
    input logic clk,
    input logic reset,
    conv_bram_1d_pass_sched_if.master bus
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_ISSUE,
        S_RUN,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic              eng_bank_q, fill_bank_q, gap_q;
    logic [PASS_W-1:0] pass_idx_q, fills_q, npass_q, np_clamp;
    logic              start_ok, active, complete;
    logic              fill_req, fill_ack, last_pass;

    assign active = (state_q == S_WAIT_BUF) ||
                    (state_q == S_ISSUE) ||
                    (state_q == S_RUN);
    assign start_ok = (state_q == S_IDLE) && bus.start;
    assign np_clamp = (bus.num_pass > PASS_W'(MAX_PASS)) ?
                      PASS_W'(MAX_PASS) : bus.num_pass;
    assign complete = (state_q == S_RUN) && bus.res_wren &&
                      (bus.res_wraddr == RES_AW'(RESULT_W - 1));
    assign last_pass = (pass_idx_q == npass_q - PASS_W'(1));

    // gap_q forces fill_req low for one cycle after each accepted fill
    assign fill_req = active && (fills_q < npass_q) &&
                      !full_q[fill_bank_q] && !gap_q;
    assign fill_ack = fill_req && bus.fill_done;

    assign bus.fill_req  = fill_req;
    assign bus.fill_bank = fill_bank_q;
    assign bus.eng_bank  = eng_bank_q;
    assign bus.fil_sel   = pass_idx_q;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        bus.busy    = active;
        bus.done    = 1'b0;
        bus.eng_val = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_pass == '0) state_d = S_FIN;
                    else                    state_d = S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: begin
                if (full_q[eng_bank_q]) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                bus.eng_val = 1'b1;
                if (bus.eng_rdy) state_d = S_RUN;
            end
            S_RUN: begin
                if (complete) state_d = last_pass ? S_FIN : S_WAIT_BUF;
            end
            S_FIN: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // fill and completion always touch opposite banks, so both may apply
    always_comb begin
        full_d = full_q;
        if (fill_ack) full_d[fill_bank_q] = 1'b1;
        if (complete) full_d[eng_bank_q]  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q      <= '0;
            eng_bank_q  <= 1'b0;
            fill_bank_q <= 1'b0;
            gap_q       <= 1'b0;
            pass_idx_q  <= '0;
            fills_q     <= '0;
            npass_q     <= '0;
        end else if (start_ok) begin
            full_q      <= '0;
            eng_bank_q  <= 1'b0;
            fill_bank_q <= 1'b0;
            gap_q       <= 1'b0;
            pass_idx_q  <= '0;
            fills_q     <= '0;
            npass_q     <= np_clamp;
        end else begin
            full_q <= full_d;
            gap_q  <= fill_ack;
            if (fill_ack) begin
                fill_bank_q <= ~fill_bank_q;
                fills_q     <= fills_q + PASS_W'(1);
            end
            if (complete) begin
                eng_bank_q <= ~eng_bank_q;
                pass_idx_q <= pass_idx_q + PASS_W'(1);
            end
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall <= '0;
        end else if (start_ok) begin
            perf_stall <= '0;
        end else if (state_q == S_WAIT_BUF && perf_stall != '1) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_bram_1d_pass_sched.sv
// Randomized scoreboard bench for the multi-pass bank scheduler.
// Loader and engine are behavioural responders; a negedge monitor checks.
module tb_conv_bram_1d_pass_sched;
    localparam int RESULT_W = 30;
    localparam int PASS_W   = 5;
    localparam int RES_AW   = 5;
    localparam int MAX_PASS = 16;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    conv_bram_1d_pass_sched_if #(.PASS_W(PASS_W), .RES_AW(RES_AW)) bus ();

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_stall;
`endif

    conv_bram_1d_pass_sched dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef CONV_SCHED_PERF_EN
        ,
        .perf_stall(perf_stall)
`endif
    );

    int n_chk;
    int n_fail;
    int ld_min, ld_max, rdy_dly;
    bit stray;
    int fill_q[$];
    int eng_q[$];
    int job_q[$];
    bit job_open;
    bit in_run;
    int passes_left, passes_started, fills_acked;
    int cyc, exp_done, fill_chk, hold, stall;
    bit prev_ack, rst_low_prev;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // loader: acknowledges each fill_req after a random delay
    initial begin
        int cnt, dly;
        cnt = 0;
        dly = 0;
        bus.fill_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                bus.fill_done = 1'b0;
                cnt = 0;
            end else if (bus.fill_done) begin
                bus.fill_done = 1'b0;
                cnt = 0;
            end else if (bus.fill_req) begin
                if (cnt == 0) dly = $urandom_range(ld_max, ld_min);
                if (cnt >= dly) begin
                    bus.fill_done = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else if (stray && $urandom_range(15, 0) == 0) begin
                bus.fill_done = 1'b1;
            end
        end
    end

    // engine: rdy after rdy_dly cycles of val, then a sparse write burst
    initial begin
        int rc, addr;
        bit run, last_val, hs;
        rc = 0;
        addr = 0;
        run = 0;
        last_val = 0;
        bus.eng_rdy = 1'b0;
        bus.res_wren = 1'b0;
        bus.res_wraddr = '0;
        forever begin
            @(posedge clk);
            #1;
            hs = bus.eng_rdy && last_val;
            bus.res_wren = 1'b0;
            if (!reset) begin
                run = 0;
                rc = 0;
                last_val = 0;
                bus.eng_rdy = 1'b0;
            end else begin
                if (hs) begin
                    run = 1;
                    addr = 0;
                end else if (run) begin
                    if ($urandom_range(3, 0) != 0) begin
                        bus.res_wren = 1'b1;
                        bus.res_wraddr = RES_AW'(addr);
                        if (addr == RESULT_W - 1) run = 0;
                        else addr++;
                    end
                end else if (stray && !bus.busy &&
                             $urandom_range(7, 0) == 0) begin
                    bus.res_wren = 1'b1;
                    bus.res_wraddr = RES_AW'(RESULT_W - 1);
                end
                if (bus.eng_val) begin
                    if (rc >= rdy_dly) begin
                        bus.eng_rdy = 1'b1;
                    end else begin
                        bus.eng_rdy = 1'b0;
                        rc++;
                    end
                end else begin
                    bus.eng_rdy = 1'b0;
                    rc = 0;
                end
                last_val = bus.eng_val;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        int e, k;
        cyc = 0;
        exp_done = -1;
        fill_chk = -1;
        hold = 0;
        stall = 0;
        prev_ack = 0;
        rst_low_prev = 0;
        in_run = 0;
        passes_left = 0;
        passes_started = 0;
        fills_acked = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (rst_low_prev)
                    chk("reset_outputs",
                        {bus.busy, bus.done, bus.fill_req, bus.fill_bank,
                         bus.eng_val, bus.eng_bank, bus.fil_sel}, 0);
                fill_q.delete();
                eng_q.delete();
                job_q.delete();
                in_run = 0;
                job_open = 0;
                exp_done = -1;
                fill_chk = -1;
                hold = 0;
                prev_ack = 0;
            end else begin
                if (bus.start && !bus.busy && !bus.done) begin
                    if (job_q.size() == 0) begin
                        chk("job_unexp", 1, 0);
                    end else begin
                        k = job_q.pop_front();
                        passes_left = k;
                        passes_started = 0;
                        fills_acked = 0;
                        stall = 0;
                        if (k == 0) exp_done = cyc + 1;
                        else fill_chk = cyc + 1;
                    end
                end
                if (cyc == fill_chk) begin
                    chk("first_fill_req",
                        {bus.busy, bus.fill_req, bus.fill_bank}, 6);
                    fill_chk = -1;
                end
                if (prev_ack) chk("fill_gap", bus.fill_req, 0);
                if (!bus.busy)
                    chk("idle_quiet", {bus.fill_req, bus.eng_val}, 0);
                if (bus.busy && !bus.eng_val && !in_run) stall++;
                prev_ack = bus.fill_req && bus.fill_done;
                if (prev_ack) begin
                    if (fill_q.size() == 0) chk("fill_unexp", 1, 0);
                    else chk("fill_bank", bus.fill_bank, fill_q.pop_front());
                    fills_acked++;
                end
                hold = bus.eng_val ? hold + 1 : 0;
                if (in_run && bus.res_wren &&
                    bus.res_wraddr == RES_AW'(RESULT_W - 1)) begin
                    in_run = 0;
                    passes_left--;
                    if (passes_left == 0) exp_done = cyc + 1;
                end
                if (bus.eng_val && bus.eng_rdy) begin
                    if (eng_q.size() == 0) begin
                        chk("eng_unexp", 1, 0);
                    end else begin
                        e = eng_q.pop_front();
                        chk("eng_bank", bus.eng_bank, e / 256);
                        chk("fil_sel", bus.fil_sel, e % 256);
                    end
                    chk("val_hold", hold, rdy_dly + 1);
                    chk("bank_ready", int'(fills_acked > passes_started), 1);
                    passes_started++;
                    in_run = 1;
                end
                if (bus.done) begin
                    chk("done_time", cyc, exp_done);
                    chk("done_busy", bus.busy, 0);
                    chk("queues_empty", fill_q.size() + eng_q.size(), 0);
`ifdef CONV_SCHED_PERF_EN
                    chk("perf_stall", perf_stall, stall);
`endif
                    exp_done = -1;
                    job_open = 0;
                end else if (cyc == exp_done) begin
                    chk("done_missing", 0, 1);
                    exp_done = -1;
                    job_open = 0;
                end
            end
            rst_low_prev = !reset;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic issue_start(int n, int lmn, int lmx, int rd, bit st);
        int k;
        ld_min = lmn;
        ld_max = lmx;
        rdy_dly = rd;
        stray = st;
        @(posedge clk);
        #2;
        k = (n > MAX_PASS) ? MAX_PASS : n;
        for (int i = 0; i < k; i++) begin
            fill_q.push_back(i % 2);
            eng_q.push_back((i % 2) * 256 + i);
        end
        job_q.push_back(k);
        job_open = 1;
        bus.start = 1'b1;
        bus.num_pass = PASS_W'(n);
    endtask

    task automatic wait_job(bit st);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #2;
            bus.start = st && bus.busy && ($urandom_range(3, 0) == 0);
            bus.num_pass = PASS_W'($urandom_range(31, 0));
            t++;
        end while (job_open && t < 6000);
        bus.start = 1'b0;
        if (job_open) begin
            chk("job_timeout", 0, 1);
            do_reset();
        end
    endtask

    task automatic run_job(int n, int lmn, int lmx, int rd, bit st);
        issue_start(n, lmn, lmx, rd, st);
        wait_job(st);
    endtask

    initial begin
        int t, lmn;
        n_chk = 0;
        n_fail = 0;
        ld_min = 0;
        ld_max = 0;
        rdy_dly = 0;
        stray = 0;
        job_open = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.num_pass = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;

        run_job(1, 5, 5, 0, 0);
        run_job(4, 0, 0, 1, 0);
        run_job(0, 0, 0, 0, 0);
        run_job(2, 100, 100, 3, 0);

        issue_start(4, 1, 2, 1, 0);
        t = 0;
        do begin
            @(posedge clk);
            #2;
            bus.start = 1'b0;
            t++;
        end while (!(passes_started == 3 && in_run) && t < 3000);
        chk("mid_run_reached", int'(passes_started == 3 && in_run), 1);
        do_reset();
        run_job(2, 1, 3, 2, 0);

        run_job(6, 0, 1, 0, 1);
        run_job(20, 0, 2, 1, 1);
        repeat (14) begin
            lmn = $urandom_range(3, 0);
            run_job($urandom_range(20, 0), lmn,
                    lmn + $urandom_range(6, 0), $urandom_range(3, 0), 1);
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
